// File: rtl/chunked_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks A and B one CHUNK at a time from the
// MSB end and stops at the first differing chunk; optional two's complement mode.
module chunked_magnitude_comparator #(
  parameter  int N     = 16,
  parameter  int CHUNK = 4,
  localparam int NCH   = N / CHUNK,
  localparam int CW    = $clog2(NCH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          signed_mode,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  output logic          busy,
  output logic          done,
  output logic          equal,
  output logic          A_greater_than_B,
  output logic          B_greater_than_A,
  output logic [CW-1:0] cycles
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  if (CHUNK < 1 || (N % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_magnitude_comparator: N must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t state, state_next;

  logic [NCH-1:0][CHUNK-1:0] a_reg, b_reg;
  logic [N-1:0]              sign_mask;
  logic [IW-1:0]             idx;
  logic [CHUNK-1:0]          a_chunk, b_chunk;
  logic                      chunk_diff, last_chunk, accept;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign sign_mask  = signed_mode ? (N'(1) << (N - 1)) : '0;
  assign a_chunk    = a_reg[idx];
  assign b_chunk    = b_reg[idx];
  assign chunk_diff = (a_chunk != b_chunk);
  assign last_chunk = (idx == '0);
  assign accept     = start && (state != COMPARE);

  assign busy = (state == COMPARE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COMPARE;
      COMPARE: if (chunk_diff || last_chunk) state_next = DONE;
      DONE:    state_next = start ? COMPARE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg            <= '0;
      b_reg            <= '0;
      idx              <= '0;
      equal            <= 1'b0;
      A_greater_than_B <= 1'b0;
      B_greater_than_A <= 1'b0;
      cycles           <= '0;
    end else if (accept) begin
      a_reg            <= A ^ sign_mask;
      b_reg            <= B ^ sign_mask;
      idx              <= IW'(NCH - 1);
      equal            <= 1'b0;
      A_greater_than_B <= 1'b0;
      B_greater_than_A <= 1'b0;
      cycles           <= '0;
    end else if (state == COMPARE) begin
      if (chunk_diff) begin
        A_greater_than_B <= (a_chunk > b_chunk);
        B_greater_than_A <= (a_chunk < b_chunk);
        cycles           <= CW'(NCH) - CW'(idx);
      end else if (last_chunk) begin
        equal  <= 1'b1;
        cycles <= CW'(NCH);
      end else begin
        idx <= idx - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chunked_magnitude_comparator.sv
// Bench for chunked_magnitude_comparator: directed cases on a CHUNK=4 instance
// plus random ops mirrored onto CHUNK=1 and CHUNK=16 instances via a scoreboard.
module tb_chunked_magnitude_comparator;

  typedef struct {
    logic eq;
    logic gt;
    logic lt;
    int   cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_main, start_aux, signed_mode;
  logic [15:0] A, B;

  logic       busy4, done4, eq4, gt4, lt4;
  logic [2:0] cyc4;
  logic       busy1, done1, eq1, gt1, lt1;
  logic [4:0] cyc1;
  logic       busy16, done16, eq16, gt16, lt16;
  logic [0:0] cyc16;

  exp_t q4[$], q1[$], q16[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  chunked_magnitude_comparator #(.N(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_main), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy4), .done(done4), .equal(eq4),
    .A_greater_than_B(gt4), .B_greater_than_A(lt4), .cycles(cyc4)
  );

  chunked_magnitude_comparator #(.N(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(start_aux), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy1), .done(done1), .equal(eq1),
    .A_greater_than_B(gt1), .B_greater_than_A(lt1), .cycles(cyc1)
  );

  chunked_magnitude_comparator #(.N(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .start(start_aux), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy16), .done(done16), .equal(eq16),
    .A_greater_than_B(gt16), .B_greater_than_A(lt16), .cycles(cyc16)
  );

  // Reference: numeric compare for the flags, leading-equal-chunk count for cycles.
  function automatic exp_t modelOp(input logic [15:0] a, input logic [15:0] b,
                                   input logic sm, input int chunk);
    exp_t        e;
    int          nch = 16 / chunk;
    int          k = 0;
    bit          stop = 0;
    logic [15:0] mask;
    mask = (chunk == 16) ? 16'hFFFF : ((16'd1 << chunk) - 16'd1);
    e.eq = (a == b);
    if (sm) begin
      e.gt = ($signed(a) > $signed(b));
      e.lt = ($signed(a) < $signed(b));
    end else begin
      e.gt = (a > b);
      e.lt = (a < b);
    end
    for (int i = nch - 1; i >= 0; i--) begin
      if (!stop) begin
        if (((a >> (i * chunk)) & mask) == ((b >> (i * chunk)) & mask)) k++;
        else stop = 1;
      end
    end
    e.cyc = (k + 1 > nch) ? nch : k + 1;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    assert (obs === expv)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic popCheck(input int unit, input logic eq, input logic gt, input logic lt,
                          input logic [31:0] cyc, input int lat);
    exp_t e;
    int   qsize;
    qsize = (unit == 4) ? q4.size() : (unit == 1) ? q1.size() : q16.size();
    if (qsize == 0) begin
      checkOutput($sformatf("u%0d.unexpected_done", unit), 32'(qsize), 32'd1);
    end else begin
      if (unit == 4) e = q4.pop_front();
      else if (unit == 1) e = q1.pop_front();
      else e = q16.pop_front();
      checkOutput($sformatf("u%0d.equal", unit), 32'(eq), 32'(e.eq));
      checkOutput($sformatf("u%0d.a_gt_b", unit), 32'(gt), 32'(e.gt));
      checkOutput($sformatf("u%0d.b_gt_a", unit), 32'(lt), 32'(e.lt));
      checkOutput($sformatf("u%0d.cycles", unit), cyc, 32'(e.cyc));
      checkOutput($sformatf("u%0d.latency", unit), 32'(lat), 32'(e.cyc));
    end
  endtask

  task automatic expectMain(input string tag, input logic eq, input logic gt,
                            input logic lt, input int cyc);
    checkOutput({tag, ".equal"}, 32'(eq4), 32'(eq));
    checkOutput({tag, ".a_gt_b"}, 32'(gt4), 32'(gt));
    checkOutput({tag, ".b_gt_a"}, 32'(lt4), 32'(lt));
    checkOutput({tag, ".cycles"}, 32'(cyc4), 32'(cyc));
  endtask

  // Polls the main instance for done; lat counts clock edges since the accept.
  task automatic waitMain(inout int lat, output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (done4) ok = 1;
    end
    checkOutput("main_done_seen", 32'(ok), 32'd1);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sm);
    bit s4, s1, s16;
    int lat;
    @(negedge clk);
    A = a; B = b; signed_mode = sm;
    start_main = 1'b1; start_aux = 1'b1;
    q4.push_back(modelOp(a, b, sm, 4));
    q1.push_back(modelOp(a, b, sm, 1));
    q16.push_back(modelOp(a, b, sm, 16));
    @(negedge clk);
    start_main = 1'b0; start_aux = 1'b0;
    checkOutput("busy_after_accept", 32'(busy4), 32'd1);
    s4 = 0; s1 = 0; s16 = 0; lat = 0;
    while (!(s4 && s1 && s16) && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done4 && !s4) begin popCheck(4, eq4, gt4, lt4, 32'(cyc4), lat); s4 = 1; end
      if (done1 && !s1) begin popCheck(1, eq1, gt1, lt1, 32'(cyc1), lat); s1 = 1; end
      if (done16 && !s16) begin popCheck(16, eq16, gt16, lt16, 32'(cyc16), lat); s16 = 1; end
    end
    checkOutput("all_units_done", {29'd0, s4, s1, s16}, 32'd7);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    bit  ok;
    bit  saw_done;
    logic [15:0] ra, rb;

    rst_n = 1'b0; start_main = 1'b0; start_aux = 1'b0; signed_mode = 1'b0;
    A = '0; B = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", 32'(busy4), 32'd0);
    checkOutput("reset.done", 32'(done4), 32'd0);
    expectMain("reset", 1'b0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;

    applyStimulus(16'h1234, 16'h1234, 1'b0);
    expectMain("eq_1234", 1'b1, 1'b0, 1'b0, 4);
    applyStimulus(16'h8000, 16'h7FFF, 1'b0);
    expectMain("u8000_7fff", 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(16'h8000, 16'h7FFF, 1'b1);
    expectMain("s8000_7fff", 1'b0, 1'b0, 1'b1, 1);
    applyStimulus(16'h1235, 16'h1234, 1'b0);
    expectMain("lsb_diff", 1'b0, 1'b1, 1'b0, 4);
    applyStimulus(16'h1204, 16'h12F0, 1'b0);
    expectMain("mid_diff", 1'b0, 1'b0, 1'b1, 3);

    // Start during busy is ignored; start in the DONE cycle is accepted.
    @(negedge clk);
    A = 16'h1234; B = 16'h1234; signed_mode = 1'b0; start_main = 1'b1;
    q4.push_back(modelOp(16'h1234, 16'h1234, 1'b0, 4));
    @(negedge clk);
    lat = 0;
    A = 16'hFFFF; B = 16'h0000; signed_mode = 1'b1;
    @(negedge clk);
    lat = 1;
    start_main = 1'b0;
    waitMain(lat, ok);
    if (ok) popCheck(4, eq4, gt4, lt4, 32'(cyc4), lat);
    expectMain("ignored_start", 1'b1, 1'b0, 1'b0, 4);
    A = 16'h8000; B = 16'h7FFF; signed_mode = 1'b1; start_main = 1'b1;
    q4.push_back(modelOp(16'h8000, 16'h7FFF, 1'b1, 4));
    @(negedge clk);
    start_main = 1'b0;
    checkOutput("b2b.busy", 32'(busy4), 32'd1);
    checkOutput("b2b.done", 32'(done4), 32'd0);
    expectMain("b2b_cleared", 1'b0, 1'b0, 1'b0, 0);
    lat = 0;
    waitMain(lat, ok);
    if (ok) popCheck(4, eq4, gt4, lt4, 32'(cyc4), lat);

    // Reset on the second COMPARE cycle aborts with no done pulse.
    @(negedge clk);
    A = 16'h1234; B = 16'h1234; signed_mode = 1'b0; start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort.busy", 32'(busy4), 32'd0);
    checkOutput("abort.done", 32'(done4), 32'd0);
    expectMain("abort", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) saw_done = 1;
    end
    checkOutput("abort.no_done", 32'(saw_done), 32'd0);
    applyStimulus(16'hFFFE, 16'h0001, 1'b1);
    expectMain("after_reset", 1'b0, 1'b0, 1'b1, 1);

    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        2:       rb = ra ^ (16'd1 << $urandom_range(0, 15));
        default: rb = ra ^ (16'($urandom) & 16'((32'd1 << $urandom_range(1, 16)) - 1));
      endcase
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
